cci_dma_burst: RTL and testbench
================================

CCI_DMA_BURST -- requirements
Module: cci_dma_burst

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, cacheline width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 42, cacheline address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 512, read-buffer depth in lines (power of 2, >= 2*MAX_BURST).
REQ-004 SHALL have parameter MAX_BURST, default 4, maximum lines per read request (legal: 1, 2, 4).
REQ-005 SHALL have ports, in order:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous active-low reset.
- rd_go  in  1  start read transfer.
- rd_addr  in  ADDR_WIDTH  read start line address.
- rd_size  in  ADDR_WIDTH+1  lines to read.
- rd_en  in  1  AFU pops read data.
- rd_data  out  DATA_WIDTH  FIFO head.
- rd_empty  out  1  read FIFO empty.
- rd_done  out  1  read transfer complete.
- wr_go  in  1  start write transfer.
- wr_addr  in  ADDR_WIDTH  write start line address.
- wr_size  in  ADDR_WIDTH+1  lines to write.
- wr_en  in  1  AFU pushes write data.
- wr_data  in  DATA_WIDTH  write line.
- wr_full  out  1  write path cannot accept.
- wr_done  out  1  write transfer complete.
- mem_rd_req_valid  out  1  read request.
- mem_rd_req_addr  out  ADDR_WIDTH  first line of request.
- mem_rd_req_len  out  2  lines-1 (0=1, 1=2, 3=4).
- mem_rd_req_almfull  in  1  read request channel back-pressure.
- mem_rd_rsp_valid  in  1  one returned line, in request order.
- mem_rd_rsp_data  in  DATA_WIDTH  returned line.
- mem_wr_req_valid  out  1  write request.
- mem_wr_req_addr  out  ADDR_WIDTH  write line address.
- mem_wr_req_data  out  DATA_WIDTH  write line.
- mem_wr_req_almfull  in  1  write channel back-pressure.
- mem_wr_rsp_valid  in  1  one write acknowledged.

Function
REQ-006 SHALL run read and write channels independently and concurrently; each has states IDLE, BUSY.
REQ-007 SHALL, on rd_go in read IDLE, latch rd_addr, rd_size into req_remaining, pop_remaining; enter BUSY next cycle; rd_go in BUSY SHALL be ignored.
REQ-008 SHALL pick burst length B per cycle: largest of {MAX_BURST,2,1} (each <= MAX_BURST) with address aligned to B and req_remaining >= B.
REQ-009 SHALL issue a read request (registered, 1-cycle latency) when BUSY, req_remaining > 0, mem_rd_req_almfull=0, and pending + B <= FIFO free space; then addr += B, req_remaining -= B, pending += B.
REQ-010 SHALL decrement pending per mem_rd_rsp_valid; simultaneous issue and response SHALL net pending += B-1.
REQ-011 SHALL push every mem_rd_rsp_valid line into the FIFO; overflow is unreachable by REQ-009.
REQ-012 SHALL pop on rd_en && !rd_empty, decrementing pop_remaining; rd_en when empty SHALL be ignored; rd_data is first-word-fall-through.
REQ-013 SHALL return read channel to IDLE and assert rd_done the cycle after pop_remaining reaches 0.
REQ-014 SHALL, on wr_go in write IDLE, latch wr_addr, wr_size into wr_remaining and ack_remaining; enter BUSY; wr_go in BUSY ignored.
REQ-015 SHALL drive wr_full = mem_wr_req_almfull || write IDLE || wr_remaining == 0.
REQ-016 SHALL, on wr_en && !wr_full, register one write request (1-cycle latency) at current address; addr += 1, wr_remaining -= 1.
REQ-017 SHALL decrement ack_remaining per mem_wr_rsp_valid; return to IDLE and assert wr_done the cycle after ack_remaining reaches 0.
REQ-018 SHALL, for size 0, enter BUSY for one cycle, issue nothing, then return to IDLE with done re-asserted.
REQ-019 SHALL deassert rd_done/wr_done the cycle after the corresponding go; done high in IDLE.
REQ-020 SHALL wrap addresses modulo 2^ADDR_WIDTH.

Reset
REQ-021 SHALL, on rst_n=0 at a clock edge (including mid-transfer), clear both channels to IDLE, flush FIFO, zero all counters; outputs: mem_rd_req_valid=0, mem_wr_req_valid=0, rd_empty=1, rd_done=1, wr_done=1, wr_full=1; responses arriving while in reset SHALL be discarded.

Verification
REQ-022 rd_go addr=0x100 size=8, MAX_BURST=4 -> two requests len=3 at 0x100, 0x104; 8 lines popped in order; rd_done after 8th pop.
REQ-023 rd_go addr=0x101 size=6 -> requests 0x101 len0, 0x102 len1, 0x104 len1, 0x106 len0.
REQ-024 FIFO_DEPTH=8, size=16, rd_en=0 -> requests stop when pending+fifo count =8; resume after pops; no overflow.
REQ-025 wr_go addr=0x200 size=3, acks delayed 10 cycles -> writes to 0x200..0x202; wr_done only after third ack; wr_full=1 after third write.
REQ-026 rst_n low mid-read with 4 pending -> all outputs at reset values; later rd_go size=2 completes correctly.
REQ-027 concurrent rd_go/wr_go, size 0 and mem_wr_req_almfull toggling -> size-0 done in 2 cycles; no write issued while almfull=1.

Source files
------------

// File: rtl/cci_dma_burst.sv
`default_nettype none
// ============================================================================
// Module   : cci_dma_burst
// Purpose  : Cacheline DMA engine with independent read and write channels.
//            Reads are coalesced into aligned bursts and land in a FWFT buffer;
//            writes are issued one line per AFU push.
// Revision : 1.0 - initial release
// ============================================================================
module cci_dma_burst #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 42,
   parameter int FIFO_DEPTH = 512,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_go,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [ADDR_WIDTH:0]   rd_size,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_empty,
   output logic                  rd_done,
   input  logic                  wr_go,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [ADDR_WIDTH:0]   wr_size,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_full,
   output logic                  wr_done,
   output logic                  mem_rd_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_rd_req_addr,
   output logic [1:0]            mem_rd_req_len,
   input  logic                  mem_rd_req_almfull,
   input  logic                  mem_rd_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rd_rsp_data,
   output logic                  mem_wr_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_wr_req_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_req_data,
   input  logic                  mem_wr_req_almfull,
   input  logic                  mem_wr_rsp_valid
);
   localparam int c_aw = $clog2(FIFO_DEPTH);
   localparam int c_cw = c_aw + 1;
   localparam int c_nw = c_cw + 2;
   localparam int c_sw = ADDR_WIDTH + 1;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} chan_state_t;

   chan_state_t           r_rd_state, w_rd_state_nxt;
   chan_state_t           r_wr_state, w_wr_state_nxt;

   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [c_sw-1:0]       r_req_rem, r_pop_rem;
   logic [c_cw-1:0]       r_pending, r_fifo_cnt;
   logic [c_aw-1:0]       r_fifo_wp, r_fifo_rp;
   logic [DATA_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];
   logic [2:0]            w_burst;
   logic [c_nw-1:0]       w_need;
   logic [c_cw-1:0]       w_pend_inc;
   logic                  w_rd_issue, w_fifo_push, w_fifo_pop, w_pend_dec;

   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [c_sw-1:0]       r_wr_rem, r_ack_rem;
   logic                  w_wr_issue;

   // Largest legal burst that is both naturally aligned and fully needed.
   always_comb begin
      w_burst = 3'd1;
      if (MAX_BURST >= 4 && r_rd_addr[1:0] == 2'b00 && r_req_rem >= c_sw'(4))
         w_burst = 3'd4;
      else if (MAX_BURST >= 2 && r_rd_addr[0] == 1'b0 && r_req_rem >= c_sw'(2))
         w_burst = 3'd2;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_state <= S_IDLE;
         r_wr_state <= S_IDLE;
      end else begin
         r_rd_state <= w_rd_state_nxt;
         r_wr_state <= w_wr_state_nxt;
      end
   end

   always_comb begin
      w_rd_state_nxt = r_rd_state;
      rd_done        = 1'b0;
      w_rd_issue     = 1'b0;
      w_need         = c_nw'(r_pending) + c_nw'(r_fifo_cnt) + c_nw'(w_burst);
      case (r_rd_state)
         S_IDLE: begin
            rd_done = 1'b1;
            if (rd_go)
               w_rd_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            w_rd_issue = (r_req_rem != '0) && !mem_rd_req_almfull &&
                         (w_need <= c_nw'(FIFO_DEPTH));
            if (r_pop_rem == '0)
               w_rd_state_nxt = S_IDLE;
         end
         default: w_rd_state_nxt = S_IDLE;
      endcase
   end

   assign rd_empty    = (r_fifo_cnt == '0);
   assign rd_data     = r_fifo_mem[r_fifo_rp];
   assign w_fifo_pop  = rd_en && !rd_empty;
   assign w_fifo_push = mem_rd_rsp_valid && (r_fifo_cnt != c_cw'(FIFO_DEPTH));
   assign w_pend_dec  = mem_rd_rsp_valid && (r_pending != '0);
   assign w_pend_inc  = w_rd_issue ? c_cw'(w_burst) : c_cw'(0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_addr        <= '0;
         r_req_rem        <= '0;
         r_pop_rem        <= '0;
         r_pending        <= '0;
         mem_rd_req_valid <= 1'b0;
         mem_rd_req_addr  <= '0;
         mem_rd_req_len   <= '0;
      end else begin
         mem_rd_req_valid <= w_rd_issue;
         r_pending        <= r_pending + w_pend_inc - c_cw'(w_pend_dec);
         if (r_rd_state == S_IDLE && rd_go) begin
            r_rd_addr <= rd_addr;
            r_req_rem <= rd_size;
            r_pop_rem <= rd_size;
         end else begin
            if (w_rd_issue) begin
               mem_rd_req_addr <= r_rd_addr;
               mem_rd_req_len  <= 2'(w_burst - 3'd1);
               r_rd_addr       <= r_rd_addr + ADDR_WIDTH'(w_burst);
               r_req_rem       <= r_req_rem - c_sw'(w_burst);
            end
            if (w_fifo_pop && r_pop_rem != '0)
               r_pop_rem <= r_pop_rem - c_sw'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_fifo_push)
         r_fifo_mem[r_fifo_wp] <= mem_rd_rsp_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fifo_wp  <= '0;
         r_fifo_rp  <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_fifo_push)
            r_fifo_wp <= r_fifo_wp + c_aw'(1);
         if (w_fifo_pop)
            r_fifo_rp <= r_fifo_rp + c_aw'(1);
         r_fifo_cnt <= r_fifo_cnt + c_cw'(w_fifo_push) - c_cw'(w_fifo_pop);
      end
   end

   // Write channel stays busy until every issued line has been acknowledged.
   always_comb begin
      w_wr_state_nxt = r_wr_state;
      wr_done        = 1'b0;
      wr_full        = 1'b1;
      case (r_wr_state)
         S_IDLE: begin
            wr_done = 1'b1;
            if (wr_go)
               w_wr_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            wr_full = mem_wr_req_almfull || (r_wr_rem == '0);
            if (r_ack_rem == '0)
               w_wr_state_nxt = S_IDLE;
         end
         default: w_wr_state_nxt = S_IDLE;
      endcase
      w_wr_issue = wr_en && !wr_full;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_addr        <= '0;
         r_wr_rem         <= '0;
         r_ack_rem        <= '0;
         mem_wr_req_valid <= 1'b0;
         mem_wr_req_addr  <= '0;
         mem_wr_req_data  <= '0;
      end else begin
         mem_wr_req_valid <= w_wr_issue;
         if (r_wr_state == S_IDLE && wr_go) begin
            r_wr_addr <= wr_addr;
            r_wr_rem  <= wr_size;
            r_ack_rem <= wr_size;
         end else begin
            if (w_wr_issue) begin
               mem_wr_req_addr <= r_wr_addr;
               mem_wr_req_data <= wr_data;
               r_wr_addr       <= r_wr_addr + ADDR_WIDTH'(1);
               r_wr_rem        <= r_wr_rem - c_sw'(1);
            end
            if (mem_wr_rsp_valid && r_ack_rem != '0)
               r_ack_rem <= r_ack_rem - c_sw'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cci_dma_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_dma_burst
// Purpose  : Self-checking bench for cci_dma_burst with a memory responder and
//            a transfer-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cci_dma_burst;
   localparam int DW    = 64;
   localparam int AW    = 12;
   localparam int DEPTH = 8;
   localparam int MB    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rd_go, rd_en, wr_go, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [AW:0]   rd_size, wr_size;
   logic [DW-1:0] rd_data, wr_data;
   logic          rd_empty, rd_done, wr_full, wr_done;
   logic          mem_rd_req_valid, mem_rd_req_almfull, mem_rd_rsp_valid;
   logic [AW-1:0] mem_rd_req_addr, mem_wr_req_addr;
   logic [1:0]    mem_rd_req_len;
   logic [DW-1:0] mem_rd_rsp_data, mem_wr_req_data;
   logic          mem_wr_req_valid, mem_wr_req_almfull, mem_wr_rsp_valid;

   always #5 clk = ~clk;

   cci_dma_burst #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_go(rd_go), .rd_addr(rd_addr), .rd_size(rd_size), .rd_en(rd_en),
      .rd_data(rd_data), .rd_empty(rd_empty), .rd_done(rd_done),
      .wr_go(wr_go), .wr_addr(wr_addr), .wr_size(wr_size), .wr_en(wr_en),
      .wr_data(wr_data), .wr_full(wr_full), .wr_done(wr_done),
      .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_addr(mem_rd_req_addr),
      .mem_rd_req_len(mem_rd_req_len), .mem_rd_req_almfull(mem_rd_req_almfull),
      .mem_rd_rsp_valid(mem_rd_rsp_valid), .mem_rd_rsp_data(mem_rd_rsp_data),
      .mem_wr_req_valid(mem_wr_req_valid), .mem_wr_req_addr(mem_wr_req_addr),
      .mem_wr_req_data(mem_wr_req_data), .mem_wr_req_almfull(mem_wr_req_almfull),
      .mem_wr_rsp_valid(mem_wr_rsp_valid)
   );

   int            tests = 0;
   int            fails = 0;
   logic [AW-1:0] exp_rq_addr[$];
   logic [1:0]    exp_rq_len[$];
   logic [AW-1:0] rsp_q[$];
   int            issued_lines = 0;
   int            popped_lines = 0;
   bit            rsp_hold = 1'b0;
   logic [AW-1:0] exp_wq_addr[$];
   logic [DW-1:0] exp_wq_data[$];
   int            ack_due[$];
   int            wr_ack_delay = 1;
   int            acks_given = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
      logic [31:0] x;
      x = 32'(a);
      return {x ^ 32'h5A5A_0000, x * 32'h9E37_79B1};
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_req_valid"}, 64'(mem_rd_req_valid), 64'(0));
      check({tag, "_wr_req_valid"}, 64'(mem_wr_req_valid), 64'(0));
      check({tag, "_rd_empty"}, 64'(rd_empty), 64'(1));
      check({tag, "_rd_done"}, 64'(rd_done), 64'(1));
      check({tag, "_wr_done"}, 64'(wr_done), 64'(1));
      check({tag, "_wr_full"}, 64'(wr_full), 64'(1));
   endtask

   // Memory read side: checks requests, returns lines in order with random gaps.
   initial begin : rd_mem
      logic [AW-1:0] ra;
      mem_rd_rsp_valid = 1'b0;
      mem_rd_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (mem_rd_req_valid === 1'b1) begin
            check("rd_req_expected", 64'(exp_rq_addr.size() > 0), 64'(1));
            if (exp_rq_addr.size() > 0) begin
               check("rd_req_addr", 64'(mem_rd_req_addr), 64'(exp_rq_addr.pop_front()));
               check("rd_req_len", 64'(mem_rd_req_len), 64'(exp_rq_len.pop_front()));
            end
            for (int i = 0; i <= int'(mem_rd_req_len); i++)
               rsp_q.push_back(mem_rd_req_addr + AW'(i));
            issued_lines += int'(mem_rd_req_len) + 1;
            check("rd_outstanding_le_depth", 64'((issued_lines - popped_lines) <= DEPTH), 64'(1));
         end
         if (!rsp_hold && rsp_q.size() > 0 && $urandom_range(3) != 0) begin
            ra               = rsp_q.pop_front();
            mem_rd_rsp_valid = 1'b1;
            mem_rd_rsp_data  = line_of(ra);
         end else begin
            mem_rd_rsp_valid = 1'b0;
            mem_rd_rsp_data  = {$urandom, $urandom};
         end
      end
   end

   // Memory write side: checks each write and acknowledges it after a delay.
   initial begin : wr_mem
      int wcyc;
      wcyc = 0;
      mem_wr_rsp_valid = 1'b0;
      forever begin
         @(negedge clk);
         wcyc++;
         if (mem_wr_req_valid === 1'b1) begin
            check("wr_req_expected", 64'(exp_wq_addr.size() > 0), 64'(1));
            if (exp_wq_addr.size() > 0) begin
               check("wr_req_addr", 64'(mem_wr_req_addr), 64'(exp_wq_addr.pop_front()));
               check("wr_req_data", 64'(mem_wr_req_data), 64'(exp_wq_data.pop_front()));
            end
            ack_due.push_back(wcyc + wr_ack_delay);
         end
         if (ack_due.size() > 0 && ack_due[0] <= wcyc) begin
            void'(ack_due.pop_front());
            mem_wr_rsp_valid = 1'b1;
            acks_given++;
         end else begin
            mem_wr_rsp_valid = 1'b0;
         end
      end
   end

   task automatic run_read(input logic [AW-1:0] addr, input int size, input int pop_pct,
                           input int stall, input int raf_pct, input int budget);
      logic [AW-1:0] a = addr;
      logic [AW-1:0] pa = addr;
      int  rem = size, left = size, cyc = 0, last_pop = -1, b;
      bit  done_seen = 1'b0;
      while (rem > 0) begin
         b = MB;
         while (b > 1 && ((int'(a) % b) != 0 || b > rem))
            b = b / 2;
         exp_rq_addr.push_back(a);
         exp_rq_len.push_back(2'(b - 1));
         a   = a + AW'(b);
         rem = rem - b;
      end
      rd_addr = addr;
      rd_size = (AW+1)'(size);
      rd_go   = 1'b1;
      @(negedge clk);
      rd_go = 1'b0;
      check("rd_done_low_after_go", 64'(rd_done), 64'(0));
      while (cyc < budget) begin
         if (rd_done) begin
            done_seen = 1'b1;
            break;
         end
         if (stall > 0 && cyc == stall)
            check("rd_fill_to_depth", 64'(issued_lines - popped_lines), 64'(DEPTH));
         mem_rd_req_almfull = ($urandom_range(99) < raf_pct);
         rd_en = (cyc >= stall) && ($urandom_range(99) < pop_pct);
         if (rd_en && !rd_empty) begin
            check("rd_no_extra_line", 64'(left > 0), 64'(1));
            check("rd_data", 64'(rd_data), 64'(line_of(pa)));
            pa = pa + AW'(1);
            left--;
            popped_lines++;
            last_pop = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      rd_en = 1'b0;
      mem_rd_req_almfull = 1'b0;
      check("rd_done_reached", 64'(done_seen), 64'(1));
      check("rd_lines_popped", 64'(left), 64'(0));
      check("rd_all_requests_seen", 64'(exp_rq_addr.size()), 64'(0));
      if (size == 0)
         check("rd_size0_latency", 64'(cyc), 64'(1));
      else
         check("rd_done_after_last_pop", 64'(cyc - last_pop), 64'(2));
   endtask

   task automatic run_write(input logic [AW-1:0] addr, input int size, input int af_pct,
                            input int budget);
      logic [AW-1:0] nxt = addr;
      int  left = size, cyc = 0;
      bit  exp_full, done_seen = 1'b0;
      acks_given = 0;
      wr_addr = addr;
      wr_size = (AW+1)'(size);
      wr_go   = 1'b1;
      @(negedge clk);
      wr_go = 1'b0;
      check("wr_done_low_after_go", 64'(wr_done), 64'(0));
      while (cyc < budget) begin
         if (wr_done) begin
            done_seen = 1'b1;
            break;
         end
         mem_wr_req_almfull = ($urandom_range(99) < af_pct);
         wr_en   = ($urandom_range(3) != 0);
         wr_data = {$urandom, $urandom};
         #1;
         exp_full = mem_wr_req_almfull || (left == 0);
         check("wr_full", 64'(wr_full), 64'(exp_full));
         if (wr_en && !exp_full) begin
            exp_wq_addr.push_back(nxt);
            exp_wq_data.push_back(wr_data);
            nxt = nxt + AW'(1);
            left--;
         end
         @(negedge clk);
         cyc++;
      end
      wr_en = 1'b0;
      mem_wr_req_almfull = 1'b0;
      check("wr_done_reached", 64'(done_seen), 64'(1));
      check("wr_acks_before_done", 64'(acks_given), 64'(size));
      check("wr_lines_written", 64'(left), 64'(0));
      if (size == 0)
         check("wr_size0_latency", 64'(cyc), 64'(1));
   endtask

   initial begin : main
      int w;
      rst_n = 1'b0;
      rd_go = 1'b0; rd_addr = '0; rd_size = '0; rd_en = 1'b0;
      wr_go = 1'b0; wr_addr = '0; wr_size = '0; wr_en = 1'b0; wr_data = '0;
      mem_rd_req_almfull = 1'b0;
      mem_wr_req_almfull = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      run_read(12'h100, 8, 100, 0, 0, 200);
      run_read(12'h101, 6, 70, 0, 0, 200);
      run_read(12'h100, 16, 100, 30, 0, 400);
      run_read(12'hFFE, 5, 60, 0, 30, 200);

      wr_ack_delay = 10;
      run_write(12'h200, 3, 0, 200);
      wr_ack_delay = 1;
      run_write(12'hFFF, 3, 30, 200);

      // Reset in the middle of a read with a full burst still outstanding.
      rsp_hold = 1'b1;
      exp_rq_addr.push_back(12'h300);
      exp_rq_len.push_back(2'd3);
      rd_addr = 12'h300;
      rd_size = 13'd4;
      rd_go   = 1'b1;
      @(negedge clk);
      rd_go = 1'b0;
      w = 0;
      while ((issued_lines - popped_lines) < 4 && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("rst_pending_built", 64'(issued_lines - popped_lines), 64'(4));
      rst_n = 1'b0;
      @(negedge clk);
      rsp_hold = 1'b0;
      repeat (8) @(negedge clk);
      check_reset_outputs("mid_read");
      rsp_q.delete();
      exp_rq_addr.delete();
      exp_rq_len.delete();
      issued_lines = 0;
      popped_lines = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_read(12'h310, 2, 100, 0, 0, 100);

      wr_ack_delay = 2;
      fork
         run_read(12'h040, 0, 50, 0, 0, 20);
         run_write(12'h050, 0, 50, 20);
      join
      fork
         run_read(12'h123, 11, 50, 0, 20, 300);
         run_write(12'h300, 6, 50, 300);
      join

      repeat (6) begin
         fork
            run_read(AW'($urandom), int'($urandom_range(1, 24)), int'($urandom_range(20, 100)),
                     0, 20, 600);
            begin
               wr_ack_delay = int'($urandom_range(1, 6));
               run_write(AW'($urandom), int'($urandom_range(1, 10)), 40, 600);
            end
         join
      end

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
